// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//
// Purpose
//   This block is the forwarding and load-use hazard controller for a
//   classic five-stage pipeline.
//   - It drives the 2-bit select codes for the EX-stage ALU operand muxes:
//     00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
//   - It detects load-use hazards. On a hazard it freezes PC and IF/ID and
//     inserts a bubble into EX.
//   - It keeps its own shadow copy of the EX, MEM and WB destination
//     information, so it needs nothing from the datapath registers.
//   - It counts load-use stall cycles for performance monitoring. The count
//     saturates instead of wrapping.
//
// Parameters
//   REGBITS  register-index width
//   CNTBITS  width of the stall-cycle counter
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   id_valid     in   1        ID holds a real instruction
//   id_rs        in   REGBITS  ID source A index
//   id_rt        in   REGBITS  ID source B index
//   id_uses_rt   in   1        ID instruction reads rt
//   id_dst       in   REGBITS  ID destination index
//   id_regwrite  in   1        ID instruction writes a register
//   id_memread   in   1        ID instruction is a load
//   flush        in   1        branch/jump taken; kill the ID instruction
//   ext_stall    in   1        memory wait; freeze all tracking state
//   fwd_a_sel    out  2        operand A mux select for the EX instruction
//   fwd_b_sel    out  2        operand B mux select for the EX instruction
//   stall_lu     out  1        load-use stall is active this cycle
//   pc_write     out  1        PC may update
//   ifid_write   out  1        IF/ID register may update
//   stall_count  out  CNTBITS  saturating count of load-use stall cycles

module forward_hazard_unit #(
    parameter int REGBITS = 5,
    parameter int CNTBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REGBITS-1:0] id_rs,
    input  logic [REGBITS-1:0] id_rt,
    input  logic               id_uses_rt,
    input  logic [REGBITS-1:0] id_dst,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               flush,
    input  logic               ext_stall,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               stall_lu,
    output logic               pc_write,
    output logic               ifid_write,
    output logic [CNTBITS-1:0] stall_count
);

    localparam logic [REGBITS-1:0] REG_ZERO = '0;
    localparam logic [CNTBITS-1:0] CNT_ZERO = '0;
    localparam logic [CNTBITS-1:0] CNT_MAX  = '1;
    localparam logic [CNTBITS-1:0] CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Shadow pipeline state
    logic               ex_valid;
    logic [REGBITS-1:0] ex_rs;
    logic [REGBITS-1:0] ex_rt;
    logic [REGBITS-1:0] ex_dst;
    logic               ex_regwr;
    logic               ex_memrd;

    logic               mem_valid;
    logic [REGBITS-1:0] mem_dst;
    logic               mem_regwr;

    logic               wb_valid;
    logic [REGBITS-1:0] wb_dst;
    logic               wb_regwr;

    logic [CNTBITS-1:0] stall_cnt_q;

    // Derived control
    logic advance;
    logic inject_bubble;
    logic mem_writes_live;
    logic wb_writes_live;
    logic ex_load_live;
    logic lu_hit_rs;
    logic lu_hit_rt;
    logic cnt_saturated;

    // The whole shadow pipeline moves together and freezes together.
    assign advance       = ~ext_stall;
    assign inject_bubble = stall_lu | flush;

    // EX stage. A load-use stall and a flush both replace the ID
    // instruction with a bubble. The bubble's fields are zeroed so that
    // stale indices never linger, even though valid=0 already masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_rs    <= REG_ZERO;
            ex_rt    <= REG_ZERO;
            ex_dst   <= REG_ZERO;
            ex_regwr <= 1'b0;
            ex_memrd <= 1'b0;
        end else if (advance) begin
            if (inject_bubble) begin
                ex_valid <= 1'b0;
                ex_rs    <= REG_ZERO;
                ex_rt    <= REG_ZERO;
                ex_dst   <= REG_ZERO;
                ex_regwr <= 1'b0;
                ex_memrd <= 1'b0;
            end else begin
                ex_valid <= id_valid;
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_dst   <= id_dst;
                ex_regwr <= id_regwrite;
                ex_memrd <= id_memread;
            end
        end
    end

    // MEM stage
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_dst   <= REG_ZERO;
            mem_regwr <= 1'b0;
        end else if (advance) begin
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            mem_regwr <= ex_regwr;
        end
    end

    // WB stage
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_dst   <= REG_ZERO;
            wb_regwr <= 1'b0;
        end else if (advance) begin
            wb_valid <= mem_valid;
            wb_dst   <= mem_dst;
            wb_regwr <= mem_regwr;
        end
    end

    // Stall-cycle counter. A cycle in which ext_stall is also high does not
    // count, because the same stall is seen again once the memory wait ends.
    assign cnt_saturated = (stall_cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= CNT_ZERO;
        end else if (advance && stall_lu && !cnt_saturated) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign stall_count = stall_cnt_q;

    // A stage can supply a value only if it really writes a register.
    // Register 0 is hard-wired to zero, so a write to it is never forwarded.
    assign mem_writes_live = mem_valid & mem_regwr & (mem_dst != REG_ZERO);
    assign wb_writes_live  = wb_valid  & wb_regwr  & (wb_dst  != REG_ZERO);

    // Operand select. MEM holds the newer value, so it wins over WB.
    // Code 11 is never produced.
    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (ex_valid) begin
            if (mem_writes_live && (mem_dst == ex_rs)) begin
                fwd_a_sel = SEL_MEM;
            end else if (wb_writes_live && (wb_dst == ex_rs)) begin
                fwd_a_sel = SEL_WB;
            end

            if (mem_writes_live && (mem_dst == ex_rt)) begin
                fwd_b_sel = SEL_MEM;
            end else if (wb_writes_live && (wb_dst == ex_rt)) begin
                fwd_b_sel = SEL_WB;
            end
        end
    end

    // Load-use detection. A load in EX has no data until the end of MEM, so
    // a consumer in ID must wait one cycle. After that wait, the load has
    // reached MEM/WB and normal forwarding covers it. A flushed ID
    // instruction is dead, so it never causes a stall.
    assign ex_load_live = ex_valid & ex_memrd & ex_regwr & (ex_dst != REG_ZERO);
    assign lu_hit_rs    = (ex_dst == id_rs);
    assign lu_hit_rt    = id_uses_rt & (ex_dst == id_rt);

    assign stall_lu = id_valid & ~flush & ex_load_live & (lu_hit_rs | lu_hit_rt);

    assign pc_write   = ~stall_lu & ~ext_stall;
    assign ifid_write = ~stall_lu & ~ext_stall;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit
//
// Purpose
//   This is the self-checking bench for forward_hazard_unit.
//   - Each cycle's stimulus is driven just after the rising edge.
//   - At the same time, a behavioural model of the shadow pipeline predicts
//     the outputs, and the prediction is queued.
//   - A checker on the falling edge pops each prediction and compares it
//     with the DUT outputs.
//   - Directed scenarios add literal expectations at their key cycles.
//   - A randomised phase follows the directed scenarios.
//   The counter is built narrow (CNTBITS=4), so saturation is reached in a
//   few dozen cycles.
//
// Ports
//   none (top-level bench)

module tb_forward_hazard_unit;

    localparam int REGBITS = 5;
    localparam int CNTBITS = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        int         cyc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       pcw;
        logic       ifw;
        logic [3:0] cnt;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               id_valid;
    logic [REGBITS-1:0] id_rs;
    logic [REGBITS-1:0] id_rt;
    logic               id_uses_rt;
    logic [REGBITS-1:0] id_dst;
    logic               id_regwrite;
    logic               id_memread;
    logic               flush;
    logic               ext_stall;
    logic [1:0]         fwd_a_sel;
    logic [1:0]         fwd_b_sel;
    logic               stall_lu;
    logic               pc_write;
    logic               ifid_write;
    logic [CNTBITS-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb[$];
    exp_t popped;

    // Model state
    instr_t     mEx, mMem, mWb;
    logic [3:0] mCnt;
    instr_t     pIns;
    logic       pFl, pEs, pRst, pStall;

    instr_t NOP;

    forward_hazard_unit #(
        .REGBITS(REGBITS),
        .CNTBITS(CNTBITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_dst     (id_dst),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .ext_stall  (ext_stall),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall_lu   (stall_lu),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic urt,
                                  input logic [4:0] dst, input logic rw,
                                  input logic mr);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urt = urt;
        i.dst = dst; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic logic [1:0] modelSel(input logic [4:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (mEx.v) begin
            if (mMem.v && mMem.rw && mMem.dst != 5'd0 && mMem.dst == src)
                r = 2'b01;
            else if (mWb.v && mWb.rw && mWb.dst != 5'd0 && mWb.dst == src)
                r = 2'b10;
        end
        return r;
    endfunction

    function automatic logic modelStall(input instr_t i, input logic fl);
        logic dep;
        dep = (mEx.dst == i.rs) || (i.urt && mEx.dst == i.rt);
        return i.v && !fl && mEx.v && mEx.mr && mEx.rw && mEx.dst != 5'd0 && dep;
    endfunction

    // Step the model over the edge that just happened, then drive the new
    // cycle's inputs and queue what the DUT must show during this cycle.
    task automatic applyStimulus(input instr_t i, input logic fl,
                                 input logic es, input logic rs);
        exp_t e;
        logic st;
        @(posedge clk);
        if (pRst) begin
            mEx = '0; mMem = '0; mWb = '0; mCnt = 4'd0;
        end else if (!pEs) begin
            if (pStall && mCnt != 4'hF) mCnt = mCnt + 4'd1;
            mWb  = mMem;
            mMem = mEx;
            mEx  = (pStall || pFl) ? '0 : pIns;
        end
        #1;
        id_valid    = i.v;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_uses_rt  = i.urt;
        id_dst      = i.dst;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        flush       = fl;
        ext_stall   = es;
        reset       = rs;
        st = modelStall(i, fl);
        e.cyc = cyc;
        e.fa  = modelSel(mEx.rs);
        e.fb  = modelSel(mEx.rt);
        e.st  = st;
        e.pcw = !st && !es;
        e.ifw = !st && !es;
        e.cnt = mCnt;
        sb.push_back(e);
        pIns = i; pFl = fl; pEs = es; pRst = rs; pStall = st;
        cyc++;
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            popped = sb.pop_front();
            checkOutput($sformatf("fwd_a@%0d", popped.cyc), 32'(fwd_a_sel), 32'(popped.fa));
            checkOutput($sformatf("fwd_b@%0d", popped.cyc), 32'(fwd_b_sel), 32'(popped.fb));
            checkOutput($sformatf("stall_lu@%0d", popped.cyc), 32'(stall_lu), 32'(popped.st));
            checkOutput($sformatf("pc_write@%0d", popped.cyc), 32'(pc_write), 32'(popped.pcw));
            checkOutput($sformatf("ifid_write@%0d", popped.cyc), 32'(ifid_write), 32'(popped.ifw));
            checkOutput($sformatf("stall_count@%0d", popped.cyc), 32'(stall_count), 32'(popped.cnt));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        NOP = '0;
        mEx = '0; mMem = '0; mWb = '0; mCnt = 4'd0;
        pIns = '0; pFl = 1'b0; pEs = 1'b0; pRst = 1'b1; pStall = 1'b0;
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        id_dst = '0; id_regwrite = 1'b0; id_memread = 1'b0;
        flush = 1'b0; ext_stall = 1'b0;

        // Reset, with a load sitting on the ID inputs that must be ignored
        applyStimulus(mk(1, 1, 2, 1, 5, 1, 1), 0, 0, 1);
        applyStimulus(NOP, 0, 0, 1);
        sampleNow();
        checkOutput("reset_fwd_a", 32'(fwd_a_sel), 32'd0);
        checkOutput("reset_stall", 32'(stall_lu), 32'd0);
        checkOutput("reset_pc_write", 32'(pc_write), 32'd1);
        checkOutput("reset_count", 32'(stall_count), 32'd0);

        // Scenario 1: an EX/MEM forward, then a MEM/WB forward, then none
        applyStimulus(mk(1, 1, 2, 1, 3, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 3, 0, 0, 6, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 3, 0, 0, 7, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s1_sel_a_mem", 32'(fwd_a_sel), 32'd1);
        applyStimulus(mk(1, 3, 0, 0, 8, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s1_sel_a_wb", 32'(fwd_a_sel), 32'd2);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s1_sel_a_retired", 32'(fwd_a_sel), 32'd0);

        // Scenario 2: MEM and WB both write r3, so MEM wins.
        // Then only WB writes r3, so WB is selected.
        applyStimulus(mk(1, 1, 2, 1, 3, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 1, 2, 1, 3, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 9, 3, 1, 10, 1, 0), 0, 0, 0);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s2_sel_b_mem_wins", 32'(fwd_b_sel), 32'd1);
        applyStimulus(mk(1, 1, 2, 1, 3, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 1, 2, 1, 4, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 9, 3, 1, 10, 1, 0), 0, 0, 0);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s2_sel_b_wb", 32'(fwd_b_sel), 32'd2);

        // Scenario 3: a load-use stall lasts exactly one cycle
        applyStimulus(NOP, 0, 0, 0);
        applyStimulus(mk(1, 1, 0, 0, 5, 1, 1), 0, 0, 0);
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s3_stall_on", 32'(stall_lu), 32'd1);
        checkOutput("s3_pc_write_off", 32'(pc_write), 32'd0);
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s3_stall_off", 32'(stall_lu), 32'd0);
        checkOutput("s3_pc_write_on", 32'(pc_write), 32'd1);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s3_sel_a_wb", 32'(fwd_a_sel), 32'd2);
        checkOutput("s3_count", 32'(stall_count), 32'd1);

        // Scenario 4: a flush kills the consumer, so there is no stall
        applyStimulus(mk(1, 1, 0, 0, 5, 1, 1), 0, 0, 0);
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 1, 0, 0);
        sampleNow();
        checkOutput("s4_stall_flushed", 32'(stall_lu), 32'd0);
        checkOutput("s4_pc_write", 32'(pc_write), 32'd1);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s4_bubble_sel_a", 32'(fwd_a_sel), 32'd0);

        // Scenario 5: an external stall freezes a pending load-use stall
        applyStimulus(mk(1, 1, 0, 0, 5, 1, 1), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 1, 0);
            sampleNow();
            checkOutput($sformatf("s5_stall_held%0d", k), 32'(stall_lu), 32'd1);
            checkOutput($sformatf("s5_pc_write%0d", k), 32'(pc_write), 32'd0);
            checkOutput($sformatf("s5_count_held%0d", k), 32'(stall_count), 32'd1);
        end
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 0, 0);
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s5_count_after", 32'(stall_count), 32'd2);
        applyStimulus(NOP, 0, 0, 0);

        // Scenario 6: register 0 never forwards and never stalls
        applyStimulus(mk(1, 1, 2, 1, 0, 1, 1), 0, 0, 0);
        applyStimulus(mk(1, 0, 0, 1, 0, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("s6_r0_no_stall", 32'(stall_lu), 32'd0);
        applyStimulus(NOP, 0, 0, 0);
        sampleNow();
        checkOutput("s6_r0_sel_a", 32'(fwd_a_sel), 32'd0);
        checkOutput("s6_r0_sel_b", 32'(fwd_b_sel), 32'd0);

        // A self-dependent load stalls every other cycle. Forty cycles
        // give more than 2^CNTBITS+2 stalls.
        for (int k = 0; k < 40; k++) applyStimulus(mk(1, 5, 5, 1, 5, 1, 1), 0, 0, 0);
        sampleNow();
        checkOutput("s6_count_saturated", 32'(stall_count), 32'd15);

        // A reset during a frozen load-use stall drops everything in flight
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 1, 1);
        applyStimulus(mk(1, 5, 2, 1, 11, 1, 0), 0, 0, 0);
        sampleNow();
        checkOutput("rst_mid_stall", 32'(stall_lu), 32'd0);
        checkOutput("rst_count", 32'(stall_count), 32'd0);

        // Randomised traffic over a small register set, to provoke matches
        for (int k = 0; k < 300; k++) begin
            applyStimulus(mk(($urandom_range(0, 7) != 0),
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0)),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 99) == 0));
        end

        sampleNow();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
